alu_ctrl_fsm: RTL and testbench
===============================

Name: alu_ctrl_fsm

Overview:
- Command sequencer that drives the datapath around the ALU: register-file read ports, A/B/C pipeline registers, status register, and the ALU op select.
- Accepts one register-register command per valid/ready handshake.
- Steps operands Rn and Rm into A and B, strobes the ALU result into C and the status register, and optionally writes C back to Rd.
- Sits between the instruction source (test harness or later decoder) and the datapath.

Parameters:
- REG_AW, 3, register-file address width (8 registers).
- OP_W, 2, ALU op width; matches the ALU ALUop encoding.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in S_WAIT)
- cmd_op  in  OP_W  00 ADD, 01 SUB, 10 AND, 11 MVN (NOT Bin)
- cmd_wb  in  1  1 = write result to Rd; 0 = status-only (compare)
- cmd_rd, cmd_rn, cmd_rm  in  REG_AW each  destination and source register numbers
- readnum  out  REG_AW  register-file read address
- writenum  out  REG_AW  register-file write address
- write  out  1  register-file write enable
- loada, loadb, loadc, loads  out  1 each  load strobes for A, B, C and status
- asel, bsel  out  1 each  operand-mux selects; 0 = register path
- vsel  out  1  write-back mux select; 0 = C
- ALUop  out  OP_W  op presented to the ALU
- busy  out  1  high in every state except S_WAIT
- done  out  1  one-cycle pulse in the final state of each command

Behaviour:
- Moore machine. All datapath strobes decode from state and the captured command only, never directly from the cmd_* inputs.
- States: S_WAIT, S_GET_A, S_GET_B, S_EXEC, S_WRITE.
- Handshake: in S_WAIT, cmd_ready=1.
  - If cmd_valid=1 at a rising edge, the command fields are captured into internal registers.
  - The FSM then moves to S_GET_A, or to S_GET_B if cmd_op=11 (MVN needs no A).
  - In all other states cmd_ready=0 and cmd_valid is ignored.
- S_GET_A: readnum=rn_q, loada=1.
- S_GET_B: readnum=rm_q, loadb=1.
- S_EXEC: asel=0, bsel=0, ALUop=op_q, loadc=1, loads=1.
- S_WRITE: vsel=0, writenum=rd_q, write=1.
- Transitions:
  - S_GET_A -> S_GET_B -> S_EXEC.
  - S_EXEC -> S_WRITE if wb_q=1, else S_WAIT.
  - S_WRITE -> S_WAIT.
- done=1 during S_WRITE, or during S_EXEC when wb_q=0. busy=1 in every state except S_WAIT.
- Latency, counted from the accept edge E0 to the cycle carrying done:
  - ADD/SUB/AND with write-back: 4 cycles.
  - MVN with write-back: 3 cycles.
  - Status-only: 3 cycles (ADD/SUB/AND) or 2 cycles (MVN).
- Back-to-back commands: a command may be accepted on the edge that leaves the done state's successor S_WAIT. Minimum spacing is latency + 1 cycles.
- Outside active states:
  - readnum, writenum and ALUop hold 0.
  - All strobes (write, loada, loadb, loadc, loads) are 0.
  - asel=bsel=vsel=0.
- Reset (reset_n=0 at a rising edge, any state including mid-command):
  - Next state S_WAIT; captured command registers cleared to 0.
  - All outputs are 0 except cmd_ready=1.
  - A partially executed command is abandoned; no write is issued.
- rd equal to rn or rm is legal; the write occurs after both reads, so there is no hazard.
- Undefined op encodings do not exist for OP_W=2.

Optional Feature:
- Macro: ALU_CTRL_CMD_CNT_EN.
- Defined:
  - Adds output port cmd_cnt [15:0].
  - The counter increments by 1 on each done pulse and wraps 16'hFFFF -> 16'h0000.
  - It clears to 0 on reset.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_ctrl_pkg holds:
  - State enum: S_WAIT=0, S_GET_A, S_GET_B, S_EXEC, S_WRITE.
  - Op constants: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_MVN=2'b11.
  - REG_AW and OP_W defaults.
- One sub-module, alu_ctrl_decode: purely combinational state plus captured command to strobe vector. alu_ctrl_fsm keeps the state register, command capture and optional counter.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n=0 for 2 cycles, then 1.
  - Required response: cmd_ready=1, busy=0, done=0, all strobes 0, readnum=writenum=ALUop=0.
- ADD with write-back:
  - Stimulus: op=00, wb=1, rd=3, rn=1, rm=2.
  - Required response, cycle by cycle: loada with readnum=1; loadb with readnum=2; loadc=loads=1 with ALUop=00; write=1 with writenum=3 and done=1; then cmd_ready=1.
- MVN:
  - Stimulus: op=11, wb=1, rd=5, rm=7.
  - Required response: no loada cycle at all; loadb with readnum=7; EXEC with ALUop=11; WRITE to writenum=5; done 3 cycles after accept.
- Status-only SUB:
  - Stimulus: op=01, wb=0, rn=4, rm=4.
  - Required response: done in S_EXEC with loads=1; write never asserts; back in S_WAIT next cycle.
- Reset mid-command:
  - Stimulus: accept ADD rd=6, then drive reset_n=0 during S_GET_B.
  - Required response: next cycle S_WAIT, all strobes 0, write never asserts for rd=6.
- Back-to-back with ALU_CTRL_CMD_CNT_EN defined:
  - Stimulus: two commands with cmd_valid held high.
  - Required response: second command accepted only when cmd_ready returns; cmd_cnt reads 0, then 1, then 2 after each done pulse.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Optional feature macro: ALU_CTRL_CMD_CNT_EN (completed-command counter).
package alu_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 3;  // 8-entry register file
  localparam int OP_W_DEFAULT   = 2;  // ALU op select width

  // Sequencer states; S_WAIT is the only idle state and must encode as 0.
  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE
  } state_t;

  // ALU op encodings, matching the datapath ALU.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Command handshake plus datapath control bundle for the ALU sequencer.
// master = instruction source side, slave = the sequencer.
interface alu_ctrl_fsm_if #(
  parameter int REG_AW = alu_ctrl_pkg::REG_AW_DEFAULT,
  parameter int OP_W   = alu_ctrl_pkg::OP_W_DEFAULT
);
  // command handshake
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic              cmd_wb;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rn;
  logic [REG_AW-1:0] cmd_rm;

  // datapath control
  logic [REG_AW-1:0] readnum;
  logic [REG_AW-1:0] writenum;
  logic              write;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic              vsel;
  logic [OP_W-1:0]   ALUop;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_wb, cmd_rd, cmd_rn, cmd_rm,
    input  cmd_ready, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, ALUop, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_wb, cmd_rd, cmd_rn, cmd_rm,
    output cmd_ready, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, ALUop, busy, done
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Moore output decode: state plus captured command -> datapath strobes.
// Purely combinational; never looks at the live cmd_* inputs.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int OP_W   = OP_W_DEFAULT
) (
  input  state_t            state,
  input  logic [OP_W-1:0]   op_q,
  input  logic              wb_q,
  input  logic [REG_AW-1:0] rd_q,
  input  logic [REG_AW-1:0] rn_q,
  input  logic [REG_AW-1:0] rm_q,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic [OP_W-1:0]   alu_op,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              vsel
);

  // Per-state strobe decode; everything idles at 0 outside its own state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    readnum   = '0;
    writenum  = '0;
    alu_op    = '0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;  // operands always come from the register path
    bsel      = 1'b0;
    vsel      = 1'b0;  // write-back always takes C
    unique case (state)
      S_WAIT: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_GET_A: begin
        readnum = rn_q;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm_q;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        alu_op = op_q;
        loadc  = 1'b1;
        loads  = 1'b1;
        done   = ~wb_q;  // compare-only commands finish here
      end
      S_WRITE: begin
        writenum = rd_q;
        write    = 1'b1;
        done     = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// ALU command sequencer: accepts one register-register command per
// valid/ready handshake and steps it through read A, read B, execute and
// optional write-back.
// Optional feature macro: ALU_CTRL_CMD_CNT_EN adds cmd_cnt[15:0], a wrapping
// count of completed commands.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int OP_W   = OP_W_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_ctrl_fsm_if.slave bus
`ifdef ALU_CTRL_CMD_CNT_EN
  ,
  output logic [15:0]   cmd_cnt
`endif
);

  state_t            state;
  state_t            state_nx;
  logic [OP_W-1:0]   op_q;
  logic              wb_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rn_q;
  logic [REG_AW-1:0] rm_q;
  logic              accept;
  logic              done_w;

  assign accept = (state == S_WAIT) && bus.cmd_valid;

  // State register and command capture; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      // NOTE: the captured command is explicitly cleared so outputs never depend on stale fields.
      state <= S_WAIT;
      op_q  <= '0;
      wb_q  <= 1'b0;
      rd_q  <= '0;
      rn_q  <= '0;
      rm_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= bus.cmd_op;
        wb_q <= bus.cmd_wb;
        rd_q <= bus.cmd_rd;
        rn_q <= bus.cmd_rn;
        rm_q <= bus.cmd_rm;
      end
    end
  end

  // Next-state logic; MVN skips the A fetch since it only uses B.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT:  if (bus.cmd_valid)
                 state_nx = (bus.cmd_op == OP_W'(ALU_MVN)) ? S_GET_B : S_GET_A;
      S_GET_A: state_nx = S_GET_B;
      S_GET_B: state_nx = S_EXEC;
      S_EXEC:  state_nx = wb_q ? S_WRITE : S_WAIT;
      S_WRITE: state_nx = S_WAIT;
      default: state_nx = S_WAIT;
    endcase
  end

  alu_ctrl_decode #(
    .REG_AW (REG_AW),
    .OP_W   (OP_W)
  ) u_decode (
    .state     (state),
    .op_q      (op_q),
    .wb_q      (wb_q),
    .rd_q      (rd_q),
    .rn_q      (rn_q),
    .rm_q      (rm_q),
    .cmd_ready (bus.cmd_ready),
    .busy      (bus.busy),
    .done      (done_w),
    .readnum   (bus.readnum),
    .writenum  (bus.writenum),
    .alu_op    (bus.ALUop),
    .write     (bus.write),
    .loada     (bus.loada),
    .loadb     (bus.loadb),
    .loadc     (bus.loadc),
    .loads     (bus.loads),
    .asel      (bus.asel),
    .bsel      (bus.bsel),
    .vsel      (bus.vsel)
  );

  assign bus.done = done_w;

`ifdef ALU_CTRL_CMD_CNT_EN
  // Completed-command counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_cnt <= '0;
    end else if (done_w) begin
      cmd_cnt <= cmd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: directed commands with literal
// per-cycle expectations, plus a transaction-level model that expands each
// accepted command into the list of cycles it must produce.
// Build with ALU_CTRL_CMD_CNT_EN defined to also cover cmd_cnt.
module tb_alu_ctrl_fsm;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_fsm_if bus ();

`ifdef ALU_CTRL_CMD_CNT_EN
  logic [15:0] cmd_cnt;
`endif

  alu_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ALU_CTRL_CMD_CNT_EN
    ,
    .cmd_cnt (cmd_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [1:0] alu_op;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       done;
  } cyc_t;

  cyc_t exp_q[$];
  bit   model_live = 0;
  int   mdl_cnt    = 0;

  // Expand one accepted command into the cycles it must occupy.
  task automatic expand(input logic [1:0] op, input logic wb,
                        input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
    cyc_t c;
    if (op != 2'b11) begin
      c = '0; c.readnum = rn; c.loada = 1'b1; exp_q.push_back(c);
    end
    c = '0; c.readnum = rm; c.loadb = 1'b1; exp_q.push_back(c);
    c = '0; c.alu_op = op; c.loadc = 1'b1; c.loads = 1'b1; c.done = ~wb; exp_q.push_back(c);
    if (wb) begin
      c = '0; c.writenum = rd; c.write = 1'b1; c.done = 1'b1; exp_q.push_back(c);
    end
  endtask

  // Model update at each rising edge.
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      mdl_cnt    = 0;
      model_live = 1;
    end else if (exp_q.size() != 0) begin
      if (exp_q[0].done) mdl_cnt = (mdl_cnt + 1) & 16'hFFFF;
      void'(exp_q.pop_front());
    end else if (bus.cmd_valid) begin
      expand(bus.cmd_op, bus.cmd_wb, bus.cmd_rd, bus.cmd_rn, bus.cmd_rm);
    end
  end

  function automatic logic [18:0] dut_vec();
    return {bus.readnum, bus.writenum, bus.ALUop, bus.write, bus.loada, bus.loadb,
            bus.loadc, bus.loads, bus.asel, bus.bsel, bus.vsel, bus.done, bus.busy,
            bus.cmd_ready};
  endfunction

  // Per-cycle comparison against the model, on the falling edge.
  initial forever begin
    cyc_t        e;
    logic        idle;
    logic [18:0] ev;
    @(negedge clk);
    if (model_live) begin
      idle = (exp_q.size() == 0);
      e    = idle ? cyc_t'('0) : exp_q[0];
      ev   = {e.readnum, e.writenum, e.alu_op, e.write, e.loada, e.loadb, e.loadc,
              e.loads, 3'b000, e.done, ~idle, idle};
      check("cycle", 32'(dut_vec()), 32'(ev));
`ifdef ALU_CTRL_CMD_CNT_EN
      check("cycle_cmd_cnt", 32'(cmd_cnt), 32'(mdl_cnt));
`endif
    end
  end

  // Watches for any write to r6 (used by the mid-command reset test).
  int w6_count = 0;
  initial forever begin
    @(negedge clk);
    if (bus.write === 1'b1 && bus.writenum === 3'd6) w6_count++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cmd(input logic [1:0] op, input logic wb,
                         input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
    bus.cmd_op = op; bus.cmd_wb = wb;
    bus.cmd_rd = rd; bus.cmd_rn = rn; bus.cmd_rm = rm;
  endtask

  // Wait for the edge that accepts the pending command; returns edges waited.
  task automatic wait_accept(output int edges);
    logic r;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = bus.cmd_ready;
      @(posedge clk);
      edges++;
      if (r) return;
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Issue one command and drop valid; returns in the first cycle after accept.
  task automatic send(input logic [1:0] op, input logic wb,
                      input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
    int n;
    set_cmd(op, wb, rd, rn, rm);
    bus.cmd_valid = 1'b1;
    wait_accept(n);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    set_cmd(2'b00, 1'b0, 3'd0, 3'd0, 3'd0);

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_strobes", 32'({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}), 32'd0);
    check("rst_addr_op", 32'({bus.readnum, bus.writenum, bus.ALUop}), 32'd0);
    @(posedge clk); #1;

    // ADD with write-back: rd=3, rn=1, rm=2
    send(2'b00, 1'b1, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    check("add_loada",   32'(bus.loada), 32'd1);
    check("add_rd_a",    32'(bus.readnum), 32'd1);
    @(negedge clk);
    check("add_loadb",   32'(bus.loadb), 32'd1);
    check("add_rd_b",    32'(bus.readnum), 32'd2);
    @(negedge clk);
    check("add_exec",    32'({bus.loadc, bus.loads}), 32'h3);
    check("add_aluop",   32'(bus.ALUop), 32'd0);
    @(negedge clk);
    check("add_write",   32'({bus.write, bus.done}), 32'h3);
    check("add_wrnum",   32'(bus.writenum), 32'd3);
    @(negedge clk);
    check("add_ready",   32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;

    // MVN with write-back: rd=5, rm=7; no A fetch
    send(2'b11, 1'b1, 3'd5, 3'd0, 3'd7);
    @(negedge clk);
    check("mvn_no_loada", 32'(bus.loada), 32'd0);
    check("mvn_loadb",    32'({bus.loadb, bus.readnum}), 32'({1'b1, 3'd7}));
    @(negedge clk);
    check("mvn_aluop",    32'({bus.loadc, bus.ALUop}), 32'({1'b1, 2'b11}));
    check("mvn_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("mvn_write",    32'({bus.write, bus.writenum, bus.done}), 32'({1'b1, 3'd5, 1'b1}));
    @(posedge clk); #1;

    // Status-only SUB: rn=rm=4
    send(2'b01, 1'b0, 3'd2, 3'd4, 3'd4);
    @(negedge clk);
    check("sub_rd_a", 32'({bus.loada, bus.readnum}), 32'({1'b1, 3'd4}));
    @(negedge clk);
    @(negedge clk);
    check("sub_done_exec", 32'({bus.loads, bus.done, bus.write}), 32'({1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    check("sub_back_wait", 32'({bus.cmd_ready, bus.write}), 32'({1'b1, 1'b0}));
    @(posedge clk); #1;

    // Status-only MVN (model-checked)
    send(2'b11, 1'b0, 3'd0, 3'd0, 3'd1);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-command: ADD rd=6, reset during S_GET_B
    w6_count = 0;
    send(2'b00, 1'b1, 3'd6, 3'd1, 3'd2);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_in_getb", 32'(bus.loadb), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_strobes", 32'({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.busy}), 32'd0);
    repeat (4) @(negedge clk);
    check("mid_no_w6", 32'(w6_count), 32'd0);
    @(posedge clk); #1;

    // Back-to-back with cmd_valid held high
`ifdef ALU_CTRL_CMD_CNT_EN
    check("b2b_cnt0", 32'(cmd_cnt), 32'd0);
`endif
    set_cmd(2'b00, 1'b1, 3'd1, 3'd2, 3'd3);
    bus.cmd_valid = 1'b1;
    wait_accept(n);
    #1;
    set_cmd(2'b10, 1'b0, 3'd7, 3'd5, 3'd6);
    wait_accept(n);
    check("b2b_spacing", 32'(n), 32'd5);
    #1;
    bus.cmd_valid = 1'b0;
`ifdef ALU_CTRL_CMD_CNT_EN
    check("b2b_cnt1", 32'(cmd_cnt), 32'd1);
`endif
    repeat (4) @(posedge clk);
    #1;
`ifdef ALU_CTRL_CMD_CNT_EN
    check("b2b_cnt2", 32'(cmd_cnt), 32'd2);
`endif
    check("b2b_idle", 32'(bus.cmd_ready), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
